uart_tx_scheduler: RTL and testbench



---
 rtl/uart_tx_scheduler.sv | 138 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that turns sensor requests into 5-byte UART frames
// (header, id, data high, data low, checksum) and drives the transmitter's init/datotx handshake.
module uart_tx_scheduler #(
    parameter int         BYTE_CYCLES = 11,
    parameter logic [7:0] HEADER      = 8'hAA
) (
    input  logic        clkBaud,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [47:0] datos,
    output logic [2:0]  ack,
    output logic        init,
    output logic [7:0]  datotx,
    output logic        ocupado
);
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2} state_t;

    localparam logic [4:0] RELOAD   = 5'(BYTE_CYCLES - 1);
    localparam logic [2:0] DONE_IDX = 3'd5;

    state_t      state, state_d;
    logic [2:0]  idx, idx_d;
    logic [4:0]  cnt, cnt_d;
    logic [1:0]  last, last_d;
    logic [1:0]  grant, grant_d;
    logic [15:0] data, data_d;
    logic [2:0]  ack_d;
    logic        init_d;
    logic [7:0]  datotx_d;
    logic        ocupado_d;
    logic [1:0]  p1, p2, pick;
    logic [7:0]  id;
    logic [7:0]  frame_byte;

    // Round-robin search starts one past the last served requester.
    always_comb begin
        p1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
        p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
        if (req[p1])      pick = p1;
        else if (req[p2]) pick = p2;
        else              pick = last;
    end

    assign id = {6'b0, grant};

    always_comb begin
        case (idx)
            3'd1:    frame_byte = id;
            3'd2:    frame_byte = data[15:8];
            3'd3:    frame_byte = data[7:0];
            3'd4:    frame_byte = id ^ data[15:8] ^ data[7:0];
            default: frame_byte = HEADER;
        endcase
    end

    always_ff @(posedge clkBaud) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 3'd0;
            cnt     <= 5'd0;
            last    <= 2'd2;
            grant   <= 2'd0;
            data    <= 16'h0000;
            ack     <= 3'b000;
            init    <= 1'b0;
            datotx  <= 8'h00;
            ocupado <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            cnt     <= cnt_d;
            last    <= last_d;
            grant   <= grant_d;
            data    <= data_d;
            ack     <= ack_d;
            init    <= init_d;
            datotx  <= datotx_d;
            ocupado <= ocupado_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (req != 3'b000) state_d = WAIT;
            WAIT:    if (cnt == 5'd0) state_d = SEND;
            SEND:    state_d = (idx == DONE_IDX) ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // SEND is a one-cycle turnaround; the registered init for that byte lands
    // in the first WAIT cycle, which keeps every pulse BYTE_CYCLES+1 apart.
    always_comb begin
        idx_d     = idx;
        cnt_d     = cnt;
        last_d    = last;
        grant_d   = grant;
        data_d    = data;
        ack_d     = 3'b000;
        init_d    = 1'b0;
        datotx_d  = datotx;
        ocupado_d = ocupado;
        case (state)
            IDLE: begin
                ocupado_d = 1'b0;
                if (req != 3'b000) begin
                    grant_d   = pick;
                    data_d    = datos[{pick, 4'b0000} +: 16];
                    ack_d     = 3'b001 << pick;
                    init_d    = 1'b1;
                    datotx_d  = HEADER;
                    ocupado_d = 1'b1;
                    idx_d     = 3'd0;
                    cnt_d     = RELOAD;
                end
            end
            WAIT: begin
                if (cnt == 5'd0) idx_d = idx + 3'd1;
                else             cnt_d = cnt - 5'd1;
            end
            SEND: begin
                if (idx == DONE_IDX) begin
                    ocupado_d = 1'b0;
                    last_d    = grant;
                    idx_d     = 3'd0;
                end else begin
                    init_d   = 1'b1;
                    datotx_d = frame_byte;
                    cnt_d    = RELOAD;
                end
            end
            default: begin
                ocupado_d = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed frame table, multi-cycle corner sequences
// and random traffic, all checked cycle by cycle against a frame-timeline model.
module tb_uart_tx_scheduler;
    localparam int         BC    = 11;
    localparam logic [7:0] HDR   = 8'hAA;
    localparam int         SLOT  = BC + 1;
    localparam int         FRAME = 5 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [47:0] datos = 48'h0;
    logic [2:0]  ack;
    logic        init;
    logic [7:0]  datotx;
    logic        ocupado;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.BYTE_CYCLES(BC), .HEADER(HDR)) dut (
        .clkBaud(clk), .rst_n(rst_n), .req(req), .datos(datos),
        .ack(ack), .init(init), .datotx(datotx), .ocupado(ocupado)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a 60-cycle window starting at its grant cycle;
    // init falls on every 12th cycle of it and the next grant needs one idle cycle.
    int         cyc = 0;
    bit         m_active = 0;
    int         m_start = 0;
    int         m_last = 2;
    int         m_grant = 0;
    logic [7:0] m_bytes[5];
    logic [7:0] m_dtx = 8'h00;

    initial forever begin
        int         off;
        int         pick;
        bit         busy_prev;
        logic [15:0] d;
        logic [7:0]  id;
        logic [2:0]  e_ack;
        logic        e_init;
        logic        e_ocu;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            m_active = 0;
            m_last   = 2;
            m_dtx    = 8'h00;
        end else begin
            busy_prev = m_active && ((cyc - 1 - m_start) < FRAME);
            if (m_active && !busy_prev) begin
                m_active = 0;
                m_last   = m_grant;
            end
            if (!busy_prev && req != 3'b000) begin
                pick = -1;
                for (int k = 1; k <= 3; k++)
                    if (pick < 0 && req[(m_last + k) % 3]) pick = (m_last + k) % 3;
                m_grant  = pick;
                m_start  = cyc;
                m_active = 1;
                d  = datos[16*pick +: 16];
                id = 8'(pick);
                m_bytes[0] = HDR;
                m_bytes[1] = id;
                m_bytes[2] = d[15:8];
                m_bytes[3] = d[7:0];
                m_bytes[4] = id ^ d[15:8] ^ d[7:0];
            end
        end
        e_ack = 3'b000; e_init = 1'b0; e_ocu = 1'b0;
        if (m_active && (cyc - m_start) < FRAME) begin
            off   = cyc - m_start;
            e_ocu = 1'b1;
            if (off % SLOT == 0) begin
                e_init = 1'b1;
                m_dtx  = m_bytes[off / SLOT];
            end
            if (off == 0) e_ack = 3'b001 << m_grant;
        end
        check("model_ack", ack, e_ack);
        check("model_init", init, e_init);
        check("model_ocupado", ocupado, e_ocu);
        check("model_datotx", datotx, m_dtx);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(output int g, output int lat);
        g = -1;
        lat = 0;
        while (g < 0 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (ack != 3'b000) g = (ack == 3'b001) ? 0 : (ack == 3'b010) ? 1 : (ack == 3'b100) ? 2 : 3;
        end
        if (g < 0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    logic [7:0] cap_bytes[5];
    int cap_n, ocu_cycles, spacing_bad, extra_ack;

    // Called at the ack cycle; follows the frame until ocupado drops.
    task automatic collect_frame(input bit scramble);
        int last_init;
        cap_n = 0; ocu_cycles = 0; spacing_bad = 0; extra_ack = 0; last_init = -1;
        for (int cnt = 0; cnt < 200 && ocupado; cnt++) begin
            if (init) begin
                if (cap_n < 5) cap_bytes[cap_n] = datotx;
                if (cap_n > 0 && cnt - last_init != SLOT) spacing_bad++;
                last_init = cnt;
                cap_n++;
            end
            if (cnt > 0 && ack != 3'b000) extra_ack++;
            ocu_cycles++;
            if (scramble) begin
                req   = (cnt < 50) ? 3'($urandom_range(0, 7)) : 3'b000;
                datos = {16'($urandom), 32'($urandom)};
            end
            @(negedge clk);
        end
        check("frame_init_count", cap_n, 5);
        check("frame_ocupado_len", ocu_cycles, FRAME);
        check("frame_init_spacing", spacing_bad, 0);
        check("frame_extra_ack", extra_ack, 0);
    endtask

    task automatic check_bytes(input string name, input logic [39:0] exp);
        logic [39:0] got;
        got = {cap_bytes[0], cap_bytes[1], cap_bytes[2], cap_bytes[3], cap_bytes[4]};
        check({name, "_hi"}, got[39:32], exp[39:32]);
        check({name, "_lo"}, got[31:0], exp[31:0]);
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [47:0] datos;
        int          grant;
        logic [39:0] bytes;
    } vec_t;

    vec_t vecs[6];
    logic [39:0] s1_exp[3];

    initial begin
        int g, lat, prev_cyc;
        vecs[0] = '{3'b001, {16'h0000, 16'h0000, 16'h1234}, 0, 40'hAA_00_12_34_26};
        vecs[1] = '{3'b010, {16'h0000, 16'hBEEF, 16'h0000}, 1, 40'hAA_01_BE_EF_50};
        vecs[2] = '{3'b100, {16'h0F0F, 16'h0000, 16'h0000}, 2, 40'hAA_02_0F_0F_02};
        vecs[3] = '{3'b111, {16'h1111, 16'h2222, 16'hFFFF}, 0, 40'hAA_00_FF_FF_00};
        vecs[4] = '{3'b110, {16'h3333, 16'h0080, 16'h4444}, 1, 40'hAA_01_00_80_81};
        vecs[5] = '{3'b100, {16'h5A3C, 16'h0000, 16'h0000}, 2, 40'hAA_02_5A_3C_64};
        s1_exp[0] = 40'hAA_00_12_34_26;
        s1_exp[1] = 40'hAA_01_BE_EF_50;
        s1_exp[2] = 40'hAA_02_0F_0F_02;

        do_reset();
        check("reset_outputs", {ack, init, ocupado, datotx}, 32'd0);

        // Table: one frame from reset per vector.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            req   = vecs[v].req;
            datos = vecs[v].datos;
            wait_ack(g, lat);
            check("tbl_grant", g, vecs[v].grant);
            check("tbl_latency", lat, 1);
            check("tbl_ack_init", {ack, init}, {3'b001 << vecs[v].grant, 1'b1});
            req = 3'b000;
            collect_frame(1'b0);
            check_bytes("tbl_bytes", vecs[v].bytes);
        end

        // All three requesting: served 0,1,2 with one idle cycle between frames.
        do_reset();
        datos = {16'h0F0F, 16'hBEEF, 16'h1234};
        req = 3'b111;
        prev_cyc = 0;
        for (int f = 0; f < 3; f++) begin
            wait_ack(g, lat);
            check("rr_order", g, f);
            if (f > 0) begin
                check("rr_gap_latency", lat, 1);
                check("rr_frame_spacing", cyc - prev_cyc, FRAME + 1);
            end
            prev_cyc = cyc;
            req = req & ~ack;
            collect_frame(1'b0);
            check_bytes("rr_bytes", s1_exp[f]);
        end

        // After serving 1, a 101 request goes to 2 first, then 0.
        do_reset();
        datos = {16'hAAAA, 16'hBBBB, 16'hCCCC};
        req = 3'b010;
        wait_ack(g, lat);
        check("ptr_first", g, 1);
        req = 3'b101;
        collect_frame(1'b0);
        wait_ack(g, lat);
        check("ptr_second", g, 2);
        req = req & ~ack;
        collect_frame(1'b0);
        wait_ack(g, lat);
        check("ptr_third", g, 0);
        req = 3'b000;
        collect_frame(1'b0);

        // Reset during byte 2 abandons the frame and restores the pointer.
        do_reset();
        datos = {16'h0000, 16'h5555, 16'h1234};
        req = 3'b001;
        wait_ack(g, lat);
        req = 3'b000;
        repeat (26) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_init", init, 1'b0);
        check("midreset_ack", ack, 3'b000);
        check("midreset_datotx", datotx, 8'h00);
        check("midreset_ocupado", ocupado, 1'b0);
        rst_n = 1'b1;
        req = 3'b110;
        wait_ack(g, lat);
        check("midreset_grant", g, 1);
        check("midreset_latency", lat, 1);
        req = 3'b000;
        collect_frame(1'b0);
        check_bytes("midreset_bytes", 40'hAA_01_55_55_01);

        // Input churn during a frame must not affect it.
        do_reset();
        datos = {16'h0000, 16'h0000, 16'hC3A5};
        req = 3'b001;
        wait_ack(g, lat);
        req = 3'b000;
        collect_frame(1'b1);
        check_bytes("churn_bytes", 40'hAA_00_C3_A5_66);

        // No requests: everything stays quiet.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_outputs", {ack, init, ocupado, datotx}, 32'd0);
        end

        // Random traffic with occasional resets, checked by the model.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) != 0);
            req   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            datos = {16'($urandom), 32'($urandom)};
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 3'b000;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
